decode_fetch_queue: RTL and testbench
=====================================

# decode_fetch_queue

Instruction byte queue and window controller that sequences the x86-64 instruction decoder. It accepts 8-byte fetch lines from the fetch side and holds them in a circular byte buffer. It presents the oldest 15 bytes as the decoder's instruction window, then retires the byte count the decoder reports after each instruction. It sits between the fetch/bus logic and the decoder and owns the fetch program counter for the window. Flush/redirect restarts it at a new address.

## Interface
Parameters:
- DEPTH_BYTES, 32, buffer capacity in bytes; power of two, at least 24
- FILL_BYTES, 8, bytes per fetch line (fixed at 8)

Ports:
- clk  in  1  clock, same as the system bus clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered bytes and restart at flush_pc
- flush_pc  in  64  address of the first byte fetched after the flush
- fill_valid  in  1  fill_data holds a valid fetch line
- fill_ready  out  1  queue can accept a fetch line this cycle
- fill_data  in  [0:63]  fetch line; byte i at bits [i*8 +: 8], byte 0 lowest address
- win_valid  out  1  window holds 15 valid bytes
- win_data  out  [0:119]  window; byte 0 (oldest) at bits [0:7]
- win_pc  out  64  address of window byte 0
- consume_valid  in  1  decoder retires consume_bytes this cycle
- consume_bytes  in  4  bytes retired, 0..15
- count  out  6  bytes currently buffered, 0..DEPTH_BYTES

## Operation
- FSM has two states.
  - IDLE: entered on reset. fill_ready=0 and win_valid=0. Consume is ignored. Leaves to RUN on flush.
  - RUN: normal operation. A flush in RUN stays in RUN.
- Storage and pointers:
  - Storage is a DEPTH_BYTES byte array with a read pointer rd and a write pointer wr. Both wrap modulo DEPTH_BYTES.
  - count is a registered occupancy, not derived from the pointers.
- fill_ready = (state==RUN) && !flush && (count <= DEPTH_BYTES-8). It uses the current count only; a same-cycle consume does not raise it.
- Fill fire = fill_valid && fill_ready. Bytes 0..7 are written at wr..wr+7 with wrap, then wr += 8.
- win_valid = (state==RUN) && (count >= 15).
- Consume fire = consume_valid && win_valid && !flush.
  - On fire: rd += consume_bytes and win_pc += consume_bytes (64-bit, wraps).
  - consume_bytes=0 is a legal no-op.
- Count update: count_next = count + (fill fire ? 8 : 0) - (consume fire ? consume_bytes : 0). Both may fire in one cycle.
- win_data is combinational from registered state: byte k = buffer[(rd+k) mod DEPTH_BYTES] for k < count. Bytes with k >= count read as 8'h00.
- Flush has priority over everything. The edge sets rd=wr=0, count=0, win_pc=flush_pc. The same cycle's fill and consume are dropped. Buffer contents need not be cleared.
- No overflow is possible, because fill_ready guarantees 8 free bytes. No underflow is possible, because consume fires only with count >= 15.

## Timing
- Reset (async, immediate) values:
  - state=IDLE, count=0, rd=wr=0, win_pc=0
  - fill_ready=0, win_valid=0, win_data=0
- Fill and consume take effect at the clock edge. count, win_valid, win_data and win_pc reflect them in the following cycle, with no extra pipeline latency.
- fill_ready and win_valid are decoded from registers and have no combinational path from fill_valid or consume_valid. fill_ready has a combinational path from flush.
- Decoder throughput is one instruction per cycle while count >= 15.
- Sustained fetch rate is one line per cycle while count <= DEPTH_BYTES-8.
- Reset asserted mid-operation returns every output to its reset value within the same cycle. Buffered bytes are lost.

## Test plan
- Reset, then stay idle: fill_valid=1 for 3 cycles gives fill_ready=0 throughout, count=0, win_valid=0, win_pc=0.
- Start and fill:
  - flush with flush_pc=64'h1000, then fill lines 00..07 and 08..0F.
  - After the first fill edge: count=8, win_valid=0, win_data bytes 8..14 read 00.
  - After the second fill edge: count=16, win_valid=1, win_data=00..0E, win_pc=64'h1000.
- Consume, then simultaneous fill and consume:
  - Consume 3 from count=16: next cycle count=13, win_valid=0, win_pc=64'h1003, win_data byte0=03.
  - Consume 5 while filling one line from count=16: next cycle count=19.
- Full boundary: fill without consuming. fill_ready deasserts once count=32. A consume of 9 that cycle gives count=23 and fill_ready=1 the next cycle.
- Wrap-around: stream 200 sequential bytes, with random consume sizes 1..15 and random fill_valid gaps. Every window must match the expected byte stream and win_pc, including across rd/wr wrap.
- Priority and async reset:
  - flush with fill_valid, consume_valid and flush_pc=64'h2000 all high at count=20: next cycle count=0, win_valid=0, win_pc=64'h2000.
  - Asserting reset mid-stream: outputs clear without waiting for a clock edge, and the queue is back in IDLE.

Source files
------------

// File: rtl/decode_fetch_queue.sv
// rtl/decode_fetch_queue.sv - instruction byte queue and 15-byte decoder window controller
module decode_fetch_queue #(
  parameter int DEPTH_BYTES = 32,
  parameter int FILL_BYTES  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [63:0]                  flush_pc,
  input  logic                         fill_valid,
  output logic                         fill_ready,
  input  logic [0:63]                  fill_data,
  output logic                         win_valid,
  output logic [0:119]                 win_data,
  output logic [63:0]                  win_pc,
  input  logic                         consume_valid,
  input  logic [3:0]                   consume_bytes,
  output logic [$clog2(DEPTH_BYTES):0] count
);

  localparam int AW       = $clog2(DEPTH_BYTES);
  localparam int CW       = AW + 1;
  localparam int WIN_SIZE = 15;

  localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH_BYTES - FILL_BYTES);
  localparam logic [CW-1:0] WIN_MIN    = CW'(WIN_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [7:0]    mem [DEPTH_BYTES];

  logic fill_fire;
  logic consume_fire;

  // Handshakes decode from registered occupancy; flush only ever masks fill_ready
  assign fill_ready   = (state == RUN) && !flush && (count <= FILL_LIMIT);
  assign win_valid    = (state == RUN) && (count >= WIN_MIN);
  assign fill_fire    = fill_valid && fill_ready;
  assign consume_fire = consume_valid && win_valid && !flush;

  // Control state, pointers, occupancy and window PC; flush overrides fill and consume
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rd     <= '0;
      wr     <= '0;
      count  <= '0;
      win_pc <= '0;
    end else if (flush) begin
      state  <= RUN;
      rd     <= '0;
      wr     <= '0;
      count  <= '0;
      win_pc <= flush_pc;
    end else begin
      if (fill_fire) begin
        wr <= wr + AW'(FILL_BYTES);
      end
      if (consume_fire) begin
        rd     <= rd + AW'(consume_bytes);
        win_pc <= win_pc + 64'(consume_bytes);
      end
      count <= count
             + (fill_fire    ? CW'(FILL_BYTES)    : '0)
             - (consume_fire ? CW'(consume_bytes) : '0);
    end
  end

  // Byte storage; contents are don't-care after flush/reset since count gates the window
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      for (int i = 0; i < FILL_BYTES; i++) begin
        mem[wr + AW'(i)] <= fill_data[i*8 +: 8];
      end
    end
  end

  // Window bytes beyond the buffered count read as zero
  always_comb begin
    win_data = '0;
    for (int k = 0; k < WIN_SIZE; k++) begin
      if (CW'(k) < count) begin
        win_data[k*8 +: 8] = mem[rd + AW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_decode_fetch_queue.sv
// tb/tb_decode_fetch_queue.sv - self-checking bench for decode_fetch_queue
module tb_decode_fetch_queue;

  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [63:0]  flush_pc;
  logic         fill_valid;
  logic         fill_ready;
  logic [0:63]  fill_data;
  logic         win_valid;
  logic [0:119] win_data;
  logic [63:0]  win_pc;
  logic         consume_valid;
  logic [3:0]   consume_bytes;
  logic [5:0]   count;

  decode_fetch_queue #(.DEPTH_BYTES(DEPTH), .FILL_BYTES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .fill_valid    (fill_valid),
    .fill_ready    (fill_ready),
    .fill_data     (fill_data),
    .win_valid     (win_valid),
    .win_data      (win_data),
    .win_pc        (win_pc),
    .consume_valid (consume_valid),
    .consume_bytes (consume_bytes),
    .count         (count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: a plain byte queue, a running flag and the window address
  logic [7:0]  mq[$];
  logic        m_run;
  logic [63:0] m_pc;
  logic        m_fill_fired;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [0:119] model_window();
    logic [0:119] w;
    w = '0;
    for (int k = 0; k < 15; k++)
      if (k < mq.size()) w[k*8 +: 8] = mq[k];
    return w;
  endfunction

  function automatic logic model_ready(input logic fl);
    return m_run && !fl && (mq.size() <= DEPTH - 8);
  endfunction

  function automatic logic model_valid();
    return m_run && (mq.size() >= 15);
  endfunction

  function automatic logic [0:63] make_line(input logic [7:0] base);
    logic [0:63] l;
    for (int i = 0; i < 8; i++) l[i*8 +: 8] = base + 8'(i);
    return l;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"},      128'(count),      128'(mq.size()));
    chk({tag, ".win_valid"},  128'(win_valid),  128'(model_valid()));
    chk({tag, ".win_pc"},     128'(win_pc),     128'(m_pc));
    chk({tag, ".win_data"},   128'(win_data),   128'(model_window()));
    chk({tag, ".fill_ready"}, 128'(fill_ready), 128'(model_ready(flush)));
  endtask

  task automatic model_reset();
    mq.delete();
    m_run = 1'b0;
    m_pc  = '0;
  endtask

  // One clock: drive inputs, check pre-edge handshakes, advance model at the edge, check after
  task automatic step(input string tag, input logic fl, input logic [63:0] fpc,
                      input logic fv, input logic [0:63] line,
                      input logic cv, input logic [3:0] cb);
    logic rdy, vld;
    flush = fl; flush_pc = fpc; fill_valid = fv; fill_data = line;
    consume_valid = cv; consume_bytes = cb;
    #1;
    rdy = model_ready(fl);
    vld = model_valid();
    chk({tag, ".pre_fill_ready"}, 128'(fill_ready), 128'(rdy));
    chk({tag, ".pre_win_valid"},  128'(win_valid),  128'(vld));
    @(posedge clk);
    m_fill_fired = 1'b0;
    if (fl) begin
      m_run = 1'b1;
      mq.delete();
      m_pc = fpc;
    end else begin
      if (cv && vld) begin
        for (int i = 0; i < int'(cb); i++) void'(mq.pop_front());
        m_pc = m_pc + 64'(cb);
      end
      if (fv && rdy) begin
        for (int i = 0; i < 8; i++) mq.push_back(line[i*8 +: 8]);
        m_fill_fired = 1'b1;
      end
    end
    #1;
    check_state(tag);
  endtask

  logic [7:0] stream_byte;

  initial begin
    reset = 1'b1; flush = 1'b0; flush_pc = '0; fill_valid = 1'b0; fill_data = '0;
    consume_valid = 1'b0; consume_bytes = '0;
    model_reset();
    #1;
    check_state("reset_async");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_state("reset_held");

    // Idle: fills and consumes are ignored
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 64'h0, 1'b1, make_line(8'h00), 1'b1, 4'd3);

    // Start and fill
    step("start_flush", 1'b1, 64'h1000, 1'b0, '0, 1'b0, 4'd0);
    step("fill1", 1'b0, 64'h0, 1'b1, make_line(8'h00), 1'b0, 4'd0);
    chk("fill1.count_const", 128'(count), 128'd8);
    chk("fill1.win_valid_const", 128'(win_valid), 128'd0);
    step("fill2", 1'b0, 64'h0, 1'b1, make_line(8'h08), 1'b0, 4'd0);
    chk("fill2.count_const", 128'(count), 128'd16);
    chk("fill2.win_data_const", 128'(win_data), 128'h000102030405060708090a0b0c0d0e);
    chk("fill2.win_pc_const", 128'(win_pc), 128'h1000);

    // Consume 3, then refill to 16 and do a simultaneous fill+consume
    step("cons3", 1'b0, 64'h0, 1'b0, '0, 1'b1, 4'd3);
    chk("cons3.count_const", 128'(count), 128'd13);
    chk("cons3.win_pc_const", 128'(win_pc), 128'h1003);
    chk("cons3.byte0_const", 128'(win_data[0:7]), 128'h03);
    step("refl_flush", 1'b1, 64'h1000, 1'b0, '0, 1'b0, 4'd0);
    step("refl_a", 1'b0, 64'h0, 1'b1, make_line(8'h00), 1'b0, 4'd0);
    step("refl_b", 1'b0, 64'h0, 1'b1, make_line(8'h08), 1'b0, 4'd0);
    step("fill_cons5", 1'b0, 64'h0, 1'b1, make_line(8'h10), 1'b1, 4'd5);
    chk("fill_cons5.count_const", 128'(count), 128'd19);

    // Full boundary
    step("full_flush", 1'b1, 64'h4000, 1'b0, '0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) step("full_fill", 1'b0, 64'h0, 1'b1, make_line(8'(8 * i)), 1'b0, 4'd0);
    chk("full.count_const", 128'(count), 128'd32);
    chk("full.ready_const", 128'(fill_ready), 128'd0);
    step("full_cons9", 1'b0, 64'h0, 1'b1, make_line(8'h20), 1'b1, 4'd9);
    chk("full_cons9.count_const", 128'(count), 128'd23);
    chk("full_cons9.ready_const", 128'(fill_ready), 128'd1);

    // Randomised streaming across pointer wrap
    step("wrap_flush", 1'b1, {$urandom, $urandom}, 1'b0, '0, 1'b0, 4'd0);
    stream_byte = 8'h00;
    for (int n = 0; n < 150; n++) begin
      step("wrap", 1'b0, 64'h0, ($urandom_range(0, 9) < 7), make_line(stream_byte),
           ($urandom_range(0, 9) < 8), 4'($urandom_range(1, 15)));
      if (m_fill_fired) stream_byte = stream_byte + 8'd8;
    end

    // Flush priority at count=20
    step("prio_flush0", 1'b1, 64'h3000, 1'b0, '0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step("prio_fill", 1'b0, 64'h0, 1'b1, make_line(8'(8 * i)), 1'b0, 4'd0);
    step("prio_cons4", 1'b0, 64'h0, 1'b0, '0, 1'b1, 4'd4);
    chk("prio.count20_const", 128'(count), 128'd20);
    step("prio", 1'b1, 64'h2000, 1'b1, make_line(8'h40), 1'b1, 4'd5);
    chk("prio.count_const", 128'(count), 128'd0);
    chk("prio.win_pc_const", 128'(win_pc), 128'h2000);

    // Async reset mid-stream
    step("pre_rst_fill", 1'b0, 64'h0, 1'b1, make_line(8'h50), 1'b0, 4'd0);
    step("pre_rst_fill", 1'b0, 64'h0, 1'b1, make_line(8'h58), 1'b0, 4'd0);
    flush = 1'b0; fill_valid = 1'b0; consume_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_state("rst_mid");
    chk("rst_mid.win_data_const", 128'(win_data), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst_idle", 1'b0, 64'h0, 1'b1, make_line(8'h60), 1'b1, 4'd2);
    step("post_rst_idle", 1'b0, 64'h0, 1'b1, make_line(8'h68), 1'b0, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
